jar_sram_host: RTL

JAR_SRAM_HOST -- requirements
Module: jar_sram_host

---
 rtl/jar_sram_host.sv | 67 ++++++
 1 files changed

// File: rtl/jar_sram_host.sv
// jar_sram_host: request/response host that bit-bangs a nibble-wide SRAM port.
// sram_in, done and req_ready are registers updated together with the state.
module jar_sram_host #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [7:0]    req_wdata,
    output logic          done,
    output logic [7:0]    rsp_rdata,
    output logic [7:0]    sram_in,
    input  logic [7:0]    sram_out
);
    typedef enum logic [3:0] {
        INIT_LO, INIT_HI, IDLE, W0_LO, W0_HI, W1_LO, W1_HI, W2_LO, W2_HI, R_LO, R_HI, R_CAP
    } state_t;
    state_t        state;
    logic [AW-1:0] addr_q;
    logic [7:0]    wdata_q;
    logic [3:0]    a_nib;
    assign a_nib = 4'(addr_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT_LO;
            sram_in   <= 8'h02;
            done      <= 1'b0;
            req_ready <= 1'b0;
            rsp_rdata <= 8'h00;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                INIT_LO: begin state <= INIT_HI; sram_in <= 8'h03; end
                INIT_HI: begin state <= IDLE; sram_in <= 8'h00; req_ready <= 1'b1; end
                IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    addr_q    <= req_addr;
                    wdata_q   <= req_wdata;
                    state     <= req_write ? W0_LO : R_LO;
                    // first SRAM word goes out straight from the accept edge
                    sram_in   <= req_write ? {req_wdata[3:0], 4'b0100} : {4'(req_addr), 4'b1000};
                end
                W0_LO: begin state <= W0_HI; sram_in <= {wdata_q[3:0], 4'b0101}; end
                W0_HI: begin state <= W1_LO; sram_in <= {wdata_q[7:4], 4'b0100}; end
                W1_LO: begin state <= W1_HI; sram_in <= {wdata_q[7:4], 4'b0101}; end
                W1_HI: begin state <= W2_LO; sram_in <= {a_nib, 4'b0100}; end
                W2_LO: begin state <= W2_HI; sram_in <= {a_nib, 4'b0101}; end
                W2_HI: begin state <= IDLE; sram_in <= 8'h00; done <= 1'b1; req_ready <= 1'b1; end
                R_LO:  begin state <= R_HI; sram_in <= {a_nib, 4'b1001}; end
                R_HI:  begin state <= R_CAP; sram_in <= {a_nib, 4'b1000}; end
                R_CAP: begin
                    state     <= IDLE;
                    sram_in   <= 8'h00;
                    done      <= 1'b1;
                    req_ready <= 1'b1;
                    rsp_rdata <= sram_out;
                end
                default: begin state <= INIT_LO; sram_in <= 8'h02; req_ready <= 1'b0; end
            endcase
        end
    end
endmodule
